ex_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register.
- Consumes the ID/EX register outputs. Performs operand forwarding, the ALU operation, branch resolution and write-register select, then registers the results for the MEM stage.
- Owns the branch-shadow squash counter that converts wrong-path instructions into bubbles.

---
 rtl/ex_pkg.sv | 41 ++++
 rtl/ex_alu.sv | 37 +++
 rtl/ex_mem_stage.sv | 138 +++++++++++++
 tb/tb_ex_mem_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: control bundles, ALU opcodes
// and the hard-wired zero register.
package ex_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] REG0 = 5'd0;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    typedef struct packed {
        logic       valid;
        logic       reg_write_en;
        logic       mem2reg_sel;
        logic       mem_write_en;
        logic       beq;
        logic       bne;
        logic       alu_src;
        logic       reg_dst_sel;
        logic [3:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write_en;
        logic mem2reg_sel;
        logic mem_write_en;
    } exmem_ctrl_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU. Shifts and LUI act on operand b; unused opcodes yield zero.
module ex_alu
    import ex_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  logic [3:0]        alu_op,
    output logic [DATA_W-1:0] result
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = b_s >>> shamt;
            ALU_LUI:  result = {b[15:0], 16'h0000};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM register, with the branch-shadow squash counter.
// Define EX_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int BRANCH_SHADOW = 2,
    parameter int CNT_W         = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              Stall_In,
    input  logic              Flush_In,
    input  ex_ctrl_t          Ctrl_In,
    input  logic [DATA_W-1:0] RegData1_In,
    input  logic [DATA_W-1:0] RegData2_In,
    input  logic [4:0]        RSAddr_In,
    input  logic [4:0]        RTAddr_In,
    input  logic [4:0]        RDAddr_In,
    input  logic [4:0]        Shamt_In,
    input  logic [15:0]       Imm_In,
    input  logic [DATA_W-1:0] PCAddr_In,
    input  logic              WbWriteEN_In,
    input  logic [4:0]        WbAddr_In,
    input  logic [DATA_W-1:0] WbData_In,
    output exmem_ctrl_t       ExMemCtrl_Out,
    output logic [DATA_W-1:0] ALUResult_Out,
    output logic [DATA_W-1:0] StoreData_Out,
    output logic [4:0]        WriteAddr_Out,
    output logic              BranchTaken_Out,
    output logic [DATA_W-1:0] BranchTarget_Out
);

    logic [CNT_W-1:0]  cnt_p1;
    exmem_ctrl_t       exmem_ctrl_p1;
    exmem_ctrl_t       exmem_ctrl_d;
    logic [DATA_W-1:0] alu_result_p1;
    logic [DATA_W-1:0] store_data_p1;
    logic [4:0]        write_addr_p1;

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        write_addr_d;
    logic              ev;
    logic              cond;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

`ifdef EX_FORWARDING_EN
    // Only ALU results are forwarded from EX/MEM; load data arrives via the WB path.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [4:0]        r,
        input logic [DATA_W-1:0] raw,
        input exmem_ctrl_t       mc,
        input logic [4:0]        ma,
        input logic [DATA_W-1:0] md,
        input logic              we,
        input logic [4:0]        wa,
        input logic [DATA_W-1:0] wd
    );
        if (r == REG0) return raw;
        if (mc.valid && mc.reg_write_en && !mc.mem2reg_sel && ma == r) return md;
        if (we && wa == r) return wd;
        return raw;
    endfunction

    assign fwd_rs = fwd(RSAddr_In, RegData1_In, exmem_ctrl_p1, write_addr_p1, alu_result_p1,
                        WbWriteEN_In, WbAddr_In, WbData_In);
    assign fwd_rt = fwd(RTAddr_In, RegData2_In, exmem_ctrl_p1, write_addr_p1, alu_result_p1,
                        WbWriteEN_In, WbAddr_In, WbData_In);
`else
    logic unused_fwd;
    assign unused_fwd = ^{RSAddr_In, WbWriteEN_In, WbAddr_In, WbData_In};
    assign fwd_rs     = RegData1_In;
    assign fwd_rt     = RegData2_In;
`endif

    assign imm_sext = {{16{Imm_In[15]}}, Imm_In};
    assign op_b     = Ctrl_In.alu_src ? imm_sext : fwd_rt;

    ex_alu u_alu (
        .a      (fwd_rs),
        .b      (op_b),
        .shamt  (Shamt_In),
        .alu_op (Ctrl_In.alu_op),
        .result (alu_result)
    );

    assign ev   = Ctrl_In.valid && (cnt_p1 == '0);
    assign cond = (Ctrl_In.beq && (fwd_rs == fwd_rt)) || (Ctrl_In.bne && (fwd_rs != fwd_rt));

    assign BranchTaken_Out  = ev && cond && !Stall_In && !Flush_In;
    assign BranchTarget_Out = PCAddr_In + {imm_sext[29:0], 2'b00};
    assign write_addr_d     = Ctrl_In.reg_dst_sel ? RDAddr_In : RTAddr_In;

    always_comb begin
        exmem_ctrl_d = '0;
        if (ev) begin
            exmem_ctrl_d.valid        = 1'b1;
            exmem_ctrl_d.reg_write_en = Ctrl_In.reg_write_en;
            exmem_ctrl_d.mem2reg_sel  = Ctrl_In.mem2reg_sel;
            exmem_ctrl_d.mem_write_en = Ctrl_In.mem_write_en;
        end
    end

    // EX -> MEM boundary
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            exmem_ctrl_p1 <= '0;
            alu_result_p1 <= '0;
            store_data_p1 <= '0;
            write_addr_p1 <= '0;
            cnt_p1        <= '0;
        end else if (Flush_In) begin
            exmem_ctrl_p1 <= '0;
            alu_result_p1 <= alu_result;
            store_data_p1 <= fwd_rt;
            write_addr_p1 <= write_addr_d;
            cnt_p1        <= '0;
        end else if (!Stall_In) begin
            exmem_ctrl_p1 <= exmem_ctrl_d;
            alu_result_p1 <= alu_result;
            store_data_p1 <= fwd_rt;
            write_addr_p1 <= write_addr_d;
            cnt_p1        <= BranchTaken_Out ? CNT_W'(BRANCH_SHADOW) : sat_dec(cnt_p1);
        end
    end

    assign ExMemCtrl_Out = exmem_ctrl_p1;
    assign ALUResult_Out = alu_result_p1;
    assign StoreData_Out = store_data_p1;
    assign WriteAddr_Out = write_addr_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a reference model checked every cycle plus literal pins.
module tb_ex_mem_stage;
    import ex_pkg::*;

    localparam int SHADOW = 2;

    logic        CLOCK = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    ex_ctrl_t    ctrl_in = '0;
    logic [31:0] rd1 = 0, rd2 = 0, pc = 0;
    logic [4:0]  rs_addr = 0, rt_addr = 0, rd_addr = 0, shamt = 0;
    logic [15:0] imm = 0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = 0;
    logic [31:0] wb_data = 0;

    exmem_ctrl_t exm;
    logic [31:0] alu_res, st_data, br_tgt;
    logic [4:0]  w_addr;
    logic        br_taken;

    ex_mem_stage #(.BRANCH_SHADOW(SHADOW), .CNT_W(2)) dut (
        .CLOCK(CLOCK), .RESET(rst), .Stall_In(stall), .Flush_In(flush), .Ctrl_In(ctrl_in),
        .RegData1_In(rd1), .RegData2_In(rd2), .RSAddr_In(rs_addr), .RTAddr_In(rt_addr),
        .RDAddr_In(rd_addr), .Shamt_In(shamt), .Imm_In(imm), .PCAddr_In(pc),
        .WbWriteEN_In(wb_we), .WbAddr_In(wb_addr), .WbData_In(wb_data),
        .ExMemCtrl_Out(exm), .ALUResult_Out(alu_res), .StoreData_Out(st_data),
        .WriteAddr_Out(w_addr), .BranchTaken_Out(br_taken), .BranchTarget_Out(br_tgt)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model state: what the EX/MEM register should hold, and slots left to squash.
    logic        m_vld = 0, m_rwe = 0, m_m2r = 0, m_mwe = 0;
    logic [31:0] m_res = 0, m_st = 0;
    logic [4:0]  m_wa = 0;
    int          m_squash = 0;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    bit          pin_zero = 0, pin_vld_en = 0, pin_vld = 0, pin_res_en = 0, pin_br_en = 0, pin_taken = 0;
    logic [31:0] pin_res = 0, pin_target = 0;

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] raw);
        if (r == 5'd0) return raw;
`ifdef EX_FORWARDING_EN
        if (m_vld && m_rwe && !m_m2r && m_wa == r) return m_res;
        if (wb_we && wb_addr == r) return wb_data;
`endif
        return raw;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return b << sh;
            4'd9:    return b >> sh;
            4'd10:   return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd11:   return b * 32'h0001_0000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic bit m_taken();
        logic [31:0] fa, fb;
        fa = m_fwd(rs_addr, rd1);
        fb = m_fwd(rt_addr, rd2);
        return ctrl_in.valid && (m_squash == 0) && !stall && !flush &&
               ((ctrl_in.beq && fa == fb) || (ctrl_in.bne && fa != fb));
    endfunction

    always @(posedge CLOCK) begin : model
        logic [31:0] fa, fb, ob, res;
        bit ev, tk;
        if (rst) begin
            m_vld = 0; m_rwe = 0; m_m2r = 0; m_mwe = 0;
            m_res = 0; m_st = 0; m_wa = 0; m_squash = 0;
        end else if (flush || !stall) begin
            fa  = m_fwd(rs_addr, rd1);
            fb  = m_fwd(rt_addr, rd2);
            ob  = ctrl_in.alu_src ? m_sext(imm) : fb;
            res = m_alu(ctrl_in.alu_op, fa, ob, shamt);
            ev  = ctrl_in.valid && (m_squash == 0) && !flush;
            tk  = m_taken();
            m_vld = ev;
            m_rwe = ev && ctrl_in.reg_write_en;
            m_m2r = ev && ctrl_in.mem2reg_sel;
            m_mwe = ev && ctrl_in.mem_write_en;
            m_res = res;
            m_st  = fb;
            m_wa  = ctrl_in.reg_dst_sel ? rd_addr : rt_addr;
            if (flush)          m_squash = 0;
            else if (tk)        m_squash = SHADOW;
            else if (m_squash > 0) m_squash = m_squash - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("taken", 32'(br_taken), 32'(m_taken()));
            chk("target", br_tgt, pc + (m_sext(imm) << 2));
            chk("valid", 32'(exm.valid), 32'(m_vld));
            chk("regwrite", 32'(exm.reg_write_en), 32'(m_rwe));
            chk("mem2reg", 32'(exm.mem2reg_sel), 32'(m_m2r));
            chk("memwrite", 32'(exm.mem_write_en), 32'(m_mwe));
            if (m_vld) begin
                chk("result", alu_res, m_res);
                chk("store", st_data, m_st);
                chk("waddr", 32'(w_addr), 32'(m_wa));
            end
            if (pin_zero) begin
                chk("pin_zero_ctrl", 32'(exm), 32'd0);
                chk("pin_zero_res", alu_res, 32'd0);
                chk("pin_zero_store", st_data, 32'd0);
                chk("pin_zero_waddr", 32'(w_addr), 32'd0);
            end
            if (pin_vld_en) chk("pin_valid", 32'(exm.valid), 32'(pin_vld));
            if (pin_res_en) chk("pin_result", alu_res, pin_res);
            if (pin_br_en) begin
                chk("pin_taken", 32'(br_taken), 32'(pin_taken));
                chk("pin_target", br_tgt, pin_target);
            end
        end
    end

    function automatic ex_ctrl_t mk(input bit v, input bit rwe, input bit m2r, input bit mwe,
                                    input bit beq, input bit bne, input bit src, input bit dst,
                                    input logic [3:0] op);
        ex_ctrl_t c;
        c.valid = v; c.reg_write_en = rwe; c.mem2reg_sel = m2r; c.mem_write_en = mwe;
        c.beq = beq; c.bne = bne; c.alu_src = src; c.reg_dst_sel = dst; c.alu_op = op;
        return c;
    endfunction

    task automatic drive(input ex_ctrl_t c, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [15:0] im, input logic [31:0] p);
        @(posedge CLOCK);
        #1;
        ctrl_in = c; rd1 = d1; rd2 = d2; rs_addr = rs; rt_addr = rt; rd_addr = rd;
        shamt = sh; imm = im; pc = p;
        rst = 0; stall = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        pin_zero = 0; pin_vld_en = 0; pin_res_en = 0; pin_br_en = 0;
    endtask

    task automatic op(input logic [3:0] o, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [4:0] sh, input logic [15:0] im, input bit src);
        drive(mk(1, 1, 0, 0, 0, 0, src, 1, o), d1, d2, 5'd1, 5'd2, 5'd4, sh, im, 32'h40);
    endtask

    task automatic nop();
        drive('0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0);
    endtask

    task automatic beq33();
        drive(mk(1, 0, 0, 0, 1, 0, 0, 0, ALU_ADD), 3, 3, 5'd1, 5'd2, 5'd5, 5'd0, 16'hFFFF, 32'h100);
    endtask

    task automatic pin_r(input logic [31:0] r);
        pin_vld_en = 1; pin_vld = 1; pin_res_en = 1; pin_res = r;
    endtask

    task automatic pin_v(input bit v);
        pin_vld_en = 1; pin_vld = v;
    endtask

    task automatic pin_b(input bit t, input logic [31:0] tg);
        pin_br_en = 1; pin_taken = t; pin_target = tg;
    endtask

    initial begin
        @(posedge CLOCK);
        #1;
        chk_en = 1;
        nop(); pin_zero = 1;

        op(ALU_ADD, 5, 7, 0, 0, 0);
        op(ALU_SUB, 5, 7, 0, 0, 0);                  pin_r(32'd12);
        op(ALU_AND, 32'hF0F0, 32'hFF00, 0, 0, 0);    pin_r(32'hFFFF_FFFE);
        op(ALU_SRA, 0, 32'h8000_0000, 31, 0, 0);     pin_r(32'h0000_F000);
        op(ALU_SLT, 32'hFFFF_FFFF, 1, 0, 0, 0);      pin_r(32'hFFFF_FFFF);
        op(ALU_SLTU, 32'hFFFF_FFFF, 1, 0, 0, 0);     pin_r(32'd1);
        op(4'd13, 3, 4, 0, 0, 0);                    pin_r(32'd0);
        op(ALU_LUI, 0, 0, 0, 16'h1234, 1);           pin_r(32'd0);
        op(ALU_NOR, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 0, 0, 0); pin_r(32'h1234_0000);
        op(ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 0, 0, 0); pin_r(32'd0);
        for (int i = 0; i < 16; i++)
            op(4'(i), $urandom, $urandom, 5'($urandom_range(31)), 16'($urandom), i[0]);

        // taken branch and its two-slot shadow
        beq33();                          pin_b(1, 32'h0000_00FC);
        op(ALU_ADD, 1, 1, 0, 0, 0);       pin_v(1);
        op(ALU_ADD, 2, 2, 0, 0, 0);       pin_v(0);
        op(ALU_ADD, 3, 3, 0, 0, 0);       pin_v(0);
        nop();                            pin_r(32'd6);
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, ALU_ADD), 3, 3, 5'd1, 5'd2, 5'd5, 5'd0, 16'h0004, 32'h200);
        pin_b(0, 32'h0000_0210);
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, ALU_ADD), 1, 2, 5'd1, 5'd2, 5'd5, 5'd0, 16'h0004, 32'h200);
        pin_b(1, 32'h0000_0210);
        nop(); nop(); nop();

        // stall inside the shadow
        beq33();                          pin_b(1, 32'h0000_00FC);
        op(ALU_ADD, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            op(ALU_ADD, 2, 2, 0, 0, 0);   stall = 1; pin_v(0);
        end
        op(ALU_ADD, 2, 2, 0, 0, 0);       pin_v(0);
        op(ALU_ADD, 4, 4, 0, 0, 0);       pin_v(0);
        beq33(); stall = 1;               pin_r(32'd8); pin_b(0, 32'h0000_00FC);
        beq33();                          pin_b(1, 32'h0000_00FC);

        // stall and flush together mid-shadow
        beq33(); stall = 1; flush = 1;    pin_b(0, 32'h0000_00FC);
        op(ALU_ADD, 5, 6, 0, 0, 0);       pin_v(0);
        beq33(); flush = 1;               pin_r(32'd11); pin_b(0, 32'h0000_00FC);
        op(ALU_ADD, 2, 3, 0, 0, 0);       pin_v(0);
        nop();                            pin_r(32'd5);

        // reset mid-shadow
        beq33();                          pin_b(1, 32'h0000_00FC);
        op(ALU_ADD, 7, 8, 0, 0, 0); rst = 1;
        op(ALU_ADD, 1, 2, 0, 0, 0);       pin_zero = 1;
        nop();                            pin_r(32'd3);

`ifdef EX_FORWARDING_EN
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, ALU_ADD), 32'h10, 0, 5'd1, 5'd2, 5'd3, 5'd0, 0, 0);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, ALU_ADD), 32'hDEAD, 0, 5'd3, 5'd0, 5'd6, 5'd0, 0, 0);
        wb_we = 1; wb_addr = 5'd3; wb_data = 32'h20;
        nop();                            pin_r(32'h10);
        drive(mk(1, 1, 1, 0, 0, 0, 0, 1, ALU_ADD), 32'h10, 0, 5'd1, 5'd2, 5'd3, 5'd0, 0, 0);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, ALU_ADD), 32'hDEAD, 0, 5'd3, 5'd0, 5'd6, 5'd0, 0, 0);
        wb_we = 1; wb_addr = 5'd3; wb_data = 32'h20;
        nop();                            pin_r(32'h20);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, ALU_ADD), 32'h10, 0, 5'd1, 5'd2, 5'd0, 5'd0, 0, 0);
        drive(mk(1, 1, 0, 0, 0, 0, 0, 1, ALU_ADD), 7, 1, 5'd0, 5'd0, 5'd6, 5'd0, 0, 0);
        wb_we = 1; wb_addr = 5'd0; wb_data = 32'h20;
        nop();                            pin_r(32'd8);
`endif

        nop();
        @(negedge CLOCK);
        #1;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
